// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for the 9-bit-instruction processor.
// Steps FETCH/DECODE/EXEC/MEM/WB and keeps cycle and retire counters.
module instr_sequencer #(
    parameter int MulLatency = 3,
    parameter int CntWidth   = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [8:0]          Instr,
    input  logic                MemReady,
    input  logic                Cond,
    output logic                IRLoad,
    output logic                PCEn,
    output logic                TakeBranch,
    output logic                RegWriteEn,
    output logic                MemReq,
    output logic                MemWriteEn,
    output logic                Done,
    output logic [2:0]          State,
    output logic [CntWidth-1:0] CycleCount,
    output logic [CntWidth-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0]          MulInit = 4'(MulLatency - 1);
    localparam logic [CntWidth-1:0] CntMax  = '1;
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_mul_cnt;
    logic [CntWidth-1:0] r_cycle_cnt;
    logic [CntWidth-1:0] r_instr_cnt;

    logic [2:0] w_opcode;
    logic [1:0] w_funct;
    logic       w_is_lb;
    logic       w_is_sb;
    logic       w_is_br;
    logic       w_is_mul;
    logic       w_is_halt;
    logic       w_is_alu;
    logic       w_mul_busy;
    logic       w_busy;
    logic       w_retire;
    logic       w_unused;

    assign w_opcode   = Instr[8:6];
    assign w_funct    = Instr[5:4];
    assign w_unused   = ^Instr[3:0];

    assign w_is_lb    = (w_opcode == 3'b001);
    assign w_is_sb    = (w_opcode == 3'b010);
    assign w_is_br    = (w_opcode == 3'b100);
    assign w_is_mul   = (w_opcode == 3'b111) && (w_funct == 2'b10);
    assign w_is_halt  = (w_opcode == 3'b111) && (w_funct == 2'b11);
    assign w_is_alu   = ~(w_is_lb | w_is_sb | w_is_br | w_is_mul | w_is_halt);

    assign w_mul_busy = w_is_mul && (r_mul_cnt != 4'd0);
    assign w_busy     = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                        (r_state == S_EXEC)  || (r_state == S_MEM)    ||
                        (r_state == S_WB);

    assign State      = r_state;
    assign CycleCount = r_cycle_cnt;
    assign InstrCount = r_instr_cnt;

    // Next-state and per-state strobe decode
    always_comb begin
        w_next     = r_state;
        IRLoad     = 1'b0;
        PCEn       = 1'b0;
        TakeBranch = 1'b0;
        RegWriteEn = 1'b0;
        MemReq     = 1'b0;
        MemWriteEn = 1'b0;
        Done       = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) w_next = S_FETCH;
            end
            S_FETCH: begin
                IRLoad = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = w_is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (w_mul_busy)             w_next = S_EXEC;
                else if (w_is_lb | w_is_sb) w_next = S_MEM;
                else                        w_next = S_WB;
            end
            S_MEM: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    if (w_is_sb) begin
                        MemWriteEn = 1'b1;
                        PCEn       = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next     = S_WB;
                    end
                end
            end
            S_WB: begin
                PCEn       = 1'b1;
                RegWriteEn = w_is_alu | w_is_mul | w_is_lb;
                TakeBranch = w_is_br & Cond;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                Done = 1'b1;
                if (!Start) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Multiply countdown: loaded in DECODE, drained in EXEC
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_mul_cnt <= 4'd0;
        end else if (r_state == S_DECODE) begin
            r_mul_cnt <= MulInit;
        end else if (r_state == S_EXEC && w_mul_busy) begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
        end
    end

    // Saturating cycle and retire counters, cleared when a run starts
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (r_state == S_IDLE && Start) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (w_busy && r_cycle_cnt != CntMax)
                r_cycle_cnt <= r_cycle_cnt + CntOne;
            if (w_retire && r_instr_cnt != CntMax)
                r_instr_cnt <= r_instr_cnt + CntOne;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer with a per-instruction cycle model.
// A second narrow-counter instance exercises counter saturation.
module tb_instr_sequencer;

    localparam int MULLAT = 3;
    localparam int MAXA   = 65535;
    localparam int MAXB   = 15;

    localparam int C_ALU  = 0;
    localparam int C_LB   = 1;
    localparam int C_SB   = 2;
    localparam int C_BR   = 3;
    localparam int C_MUL  = 4;
    localparam int C_HALT = 5;

    // {IRLoad, PCEn, TakeBranch, RegWriteEn, MemReq, MemWriteEn, Done}
    localparam logic [6:0] O_IRL = 7'b1000000;
    localparam logic [6:0] O_PCE = 7'b0100000;
    localparam logic [6:0] O_TKB = 7'b0010000;
    localparam logic [6:0] O_RWE = 7'b0001000;
    localparam logic [6:0] O_MRQ = 7'b0000100;
    localparam logic [6:0] O_MWE = 7'b0000010;
    localparam logic [6:0] O_DN  = 7'b0000001;
    localparam logic [6:0] O_NO  = 7'b0000000;

    typedef struct {
        logic       rst;
        logic       start;
        logic [8:0] instr;
        logic       mrdy;
        logic       cond;
        bit         chk;
        logic [2:0] st;
        logic [6:0] outs;
        int         ca;
        int         ia;
        int         cb;
        int         ib;
        int         lit_c;
        int         lit_i;
        int         lit_cb;
    } cyc_t;

    cyc_t q[$];
    int   ma_c, ma_i, mb_c, mb_i;
    int   last_fetch;
    int   n_tests, n_fail;
    int   cur;
    bit   running;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  instr;
    logic        mrdy;
    logic        cond;

    logic        a_irl, a_pce, a_tkb, a_rwe, a_mrq, a_mwe, a_dn;
    logic [2:0]  a_st;
    logic [15:0] a_cyc, a_icnt;
    logic        b_irl, b_pce, b_tkb, b_rwe, b_mrq, b_mwe, b_dn;
    logic [2:0]  b_st;
    logic [3:0]  b_cyc, b_icnt;

    instr_sequencer #(.MulLatency(MULLAT), .CntWidth(16)) dut_a (
        .Clk(clk), .Reset(rst_n), .Start(start), .Instr(instr),
        .MemReady(mrdy), .Cond(cond),
        .IRLoad(a_irl), .PCEn(a_pce), .TakeBranch(a_tkb),
        .RegWriteEn(a_rwe), .MemReq(a_mrq), .MemWriteEn(a_mwe),
        .Done(a_dn), .State(a_st), .CycleCount(a_cyc), .InstrCount(a_icnt)
    );

    instr_sequencer #(.MulLatency(MULLAT), .CntWidth(4)) dut_b (
        .Clk(clk), .Reset(rst_n), .Start(start), .Instr(instr),
        .MemReady(mrdy), .Cond(cond),
        .IRLoad(b_irl), .PCEn(b_pce), .TakeBranch(b_tkb),
        .RegWriteEn(b_rwe), .MemReq(b_mrq), .MemWriteEn(b_mwe),
        .Done(b_dn), .State(b_st), .CycleCount(b_cyc), .InstrCount(b_icnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    function automatic logic [8:0] gen(input int cls);
        logic [8:0] r;
        int p;
        r = 9'($urandom);
        case (cls)
            C_LB:   r[8:6] = 3'b001;
            C_SB:   r[8:6] = 3'b010;
            C_BR:   r[8:6] = 3'b100;
            C_MUL:  r[8:4] = 5'b11110;
            C_HALT: r[8:4] = 5'b11111;
            default: begin
                p = $urandom_range(0, 4);
                case (p)
                    0: r[8:6] = 3'b000;
                    1: r[8:6] = 3'b011;
                    2: r[8:6] = 3'b101;
                    3: r[8:6] = 3'b110;
                    default: begin
                        r[8:6] = 3'b111;
                        r[5]   = 1'b0;
                    end
                endcase
            end
        endcase
        return r;
    endfunction

    // One cycle of stimulus plus what the outputs must be in it;
    // counters are advanced by the spec's counting rules afterwards.
    task automatic push(input logic rst, input logic st_in,
                        input logic [8:0] ins, input logic mr,
                        input logic cd, input logic [2:0] st,
                        input logic [6:0] o, input bit ret,
                        input bit ck);
        cyc_t c;
        c.rst = rst; c.start = st_in; c.instr = ins;
        c.mrdy = mr; c.cond = cd; c.chk = ck;
        c.st = st; c.outs = o;
        c.ca = ma_c; c.ia = ma_i; c.cb = mb_c; c.ib = mb_i;
        c.lit_c = -1; c.lit_i = -1; c.lit_cb = -1;
        q.push_back(c);
        if (!rst || (st == 3'd0 && st_in)) begin
            ma_c = 0; ma_i = 0; mb_c = 0; mb_i = 0;
        end else begin
            if (st >= 3'd1 && st <= 3'd5) begin
                ma_c = sat(ma_c, MAXA);
                mb_c = sat(mb_c, MAXB);
            end
            if (ret) begin
                ma_i = sat(ma_i, MAXA);
                mb_i = sat(mb_i, MAXB);
            end
        end
    endtask

    task automatic idle_start(input int n);
        for (int k = 0; k < n; k++)
            push(1, 0, 9'($urandom), rb(), rb(), 3'd0, O_NO, 0, 1);
        push(1, 1, 9'($urandom), rb(), rb(), 3'd0, O_NO, 0, 1);
    endtask

    // Whole instruction as a list of cycles built from the timing rules
    task automatic do_instr(input int cls, input int w, input int cnd,
                            input bit rmid);
        logic [8:0] ins;
        int nw;
        logic cv;
        ins = gen(cls);
        last_fetch = q.size();
        push(1, rb(), 9'($urandom), rb(), rb(), 3'd1, O_IRL, 0, 1);
        push(1, rb(), ins, rb(), rb(), 3'd2, O_NO, 0, 1);
        if (cls == C_HALT) begin
            nw = $urandom_range(0, 3);
            for (int k = 0; k <= nw; k++)
                push(1, 1, ins, rb(), rb(), 3'd6, O_DN, 0, 1);
            push(1, 0, ins, rb(), rb(), 3'd6, O_DN, 0, 1);
            return;
        end
        nw = (cls == C_MUL) ? MULLAT : 1;
        for (int k = 0; k < nw; k++)
            push(1, rb(), ins, rb(), rb(), 3'd3, O_NO, 0, 1);
        if (cls == C_LB || cls == C_SB) begin
            if (rmid) begin
                push(0, 1, ins, 1, rb(), 3'd4,
                     (cls == C_SB) ? (O_MRQ | O_MWE | O_PCE) : O_MRQ, 0, 1);
                return;
            end
            nw = (w < 0) ? $urandom_range(0, 3) : w;
            for (int k = 0; k < nw; k++)
                push(1, rb(), ins, 0, rb(), 3'd4, O_MRQ, 0, 1);
            if (cls == C_SB) begin
                push(1, rb(), ins, 1, rb(), 3'd4, O_MRQ | O_MWE | O_PCE, 1, 1);
                return;
            end
            push(1, rb(), ins, 1, rb(), 3'd4, O_MRQ, 0, 1);
        end
        cv = (cnd < 0) ? rb() : 1'(cnd);
        push(1, rb(), ins, rb(), cv, 3'd5,
             O_PCE | ((cls == C_BR) ? (cv ? O_TKB : O_NO) : O_RWE), 1, 1);
    endtask

    task automatic pin(input int c, input int i, input int cb);
        q[last_fetch].lit_c  = c;
        q[last_fetch].lit_i  = i;
        q[last_fetch].lit_cb = cb;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h",
                         nm, cur, act, exp);
        end
    endtask

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        cyc_t c;
        if (running) begin
            c = q[cur];
            if (c.chk) begin
                check("state_a", 32'(a_st), 32'(c.st));
                check("outs_a", 32'({a_irl, a_pce, a_tkb, a_rwe,
                                      a_mrq, a_mwe, a_dn}), 32'(c.outs));
                check("cyc_a", 32'(a_cyc), c.ca);
                check("icnt_a", 32'(a_icnt), c.ia);
                check("state_b", 32'(b_st), 32'(c.st));
                check("outs_b", 32'({b_irl, b_pce, b_tkb, b_rwe,
                                      b_mrq, b_mwe, b_dn}), 32'(c.outs));
                check("cyc_b", 32'(b_cyc), c.cb);
                check("icnt_b", 32'(b_icnt), c.ib);
                if (c.lit_c >= 0)  check("lit_cyc", 32'(a_cyc), c.lit_c);
                if (c.lit_i >= 0)  check("lit_icnt", 32'(a_icnt), c.lit_i);
                if (c.lit_cb >= 0) check("lit_cyc_b", 32'(b_cyc), c.lit_cb);
            end
        end
    end

    initial begin
        int r;
        n_tests = 0; n_fail = 0; cur = 0; running = 0;
        ma_c = 0; ma_i = 0; mb_c = 0; mb_i = 0;
        rst_n = 1'b0; start = 1'b1; instr = '0; mrdy = 1'b0; cond = 1'b0;

        push(0, 1, 9'($urandom), rb(), rb(), 3'd0, O_NO, 0, 0);
        push(0, 1, 9'($urandom), rb(), rb(), 3'd0, O_NO, 0, 1);
        idle_start(0);

        do_instr(C_ALU, -1, -1, 0);
        pin(0, 0, 0);
        do_instr(C_MUL, -1, -1, 0);
        pin(4, 1, 4);
        do_instr(C_LB, 2, -1, 0);
        pin(10, 2, 10);
        do_instr(C_SB, 0, -1, 0);
        pin(17, 3, 15);
        do_instr(C_BR, -1, 1, 0);
        pin(21, 4, 15);
        do_instr(C_BR, -1, 0, 0);
        pin(25, 5, 15);
        do_instr(C_HALT, -1, -1, 0);
        pin(29, 6, 15);
        idle_start(1);

        for (int k = 0; k < 25; k++)
            do_instr($urandom_range(0, 4), -1, -1, 0);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_instr(C_HALT, -1, -1, 0);
                idle_start($urandom_range(0, 2));
            end else if (r < 6) begin
                do_instr((r < 5) ? C_LB : C_SB, -1, -1, 1);
                idle_start(1 + $urandom_range(0, 2));
            end else begin
                do_instr($urandom_range(0, 4), -1, -1, 0);
            end
        end
        do_instr(C_HALT, -1, -1, 0);

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n = q[i].rst;
            start = q[i].start;
            instr = q[i].instr;
            mrdy  = q[i].mrdy;
            cond  = q[i].cond;
            cur   = i;
            running = 1;
        end
        @(posedge clk);
        #1;
        running = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle sequencer for the 9-bit-instruction processor. It steps each instruction through fetch, decode, execute, memory and writeback, and holds multi-cycle multiplies and memory accesses until they complete. It gates the decoder's write and PC enables so each one fires in exactly one cycle. It sits between the top-level start/done handshake and the datapath (PC, instruction register, register file, data memory), and keeps cycle and retired-instruction counters.

## Interface
- MulLatency, 3: total EXEC cycles for mul; legal range 1–15.
- CntWidth, 16: width of both performance counters.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  run request; level-sensitive.
- Instr  in  9  instruction register contents; valid from DECODE onward. opcode = Instr[8:6], funct = Instr[5:4].
- MemReady  in  1  data memory completion for the current MemReq.
- Cond  in  1  branch condition from the ALU flags.
- IRLoad  out  1  load the instruction register.
- PCEn  out  1  update the PC.
- TakeBranch  out  1  PC source select: 1 = branch target.
- RegWriteEn  out  1  register file write strobe.
- MemReq  out  1  data memory request.
- MemWriteEn  out  1  data memory write strobe.
- Done  out  1  program halted.
- State  out  3  current state encoding, for debug.
- CycleCount  out  CntWidth  cycles since the run started.
- InstrCount  out  CntWidth  retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and recovers to IDLE on the next cycle.
- Instruction classes:
  - lb: opcode 001.
  - sb: opcode 010.
  - branch: opcode 100.
  - mul: opcode 111, funct 10.
  - halt: opcode 111, funct 11.
  - ALU: every other encoding.
- State transitions:
  - IDLE: when Start=1, go to FETCH and clear both counters.
  - FETCH: IRLoad=1, then go to DECODE.
  - DECODE: halt goes to HALT; everything else goes to EXEC. Load MulCnt = MulLatency-1 (4 bits).
  - EXEC: for mul with MulCnt≠0, decrement MulCnt and stay. Otherwise lb/sb go to MEM and all other classes go to WB.
  - MEM: MemReq=1 and stay until MemReady=1.
    - sb: MemWriteEn=1 only in the cycle MemReady=1. In that cycle PCEn=1, go to FETCH, and the instruction retires.
    - lb: go to WB on MemReady=1.
  - WB: PCEn=1 and go to FETCH; the instruction retires.
    - RegWriteEn=1 for ALU, mul and lb; 0 for branch.
    - TakeBranch=Cond for branch, 0 otherwise.
  - HALT: Done=1. Go to IDLE when Start=0. Done clears in IDLE.
- Output values: all outputs not listed for a state are 0. All outputs except the counters are combinational decodes of the current state and inputs.
- Counters:
  - CycleCount increments every cycle in FETCH through WB and holds in HALT and IDLE.
  - InstrCount increments on each retirement.
  - Halt does not count as a retirement.
  - Both counters saturate at all-ones and never wrap.
- Start: ignored outside IDLE. Start held high through HALT does not restart; it must fall first.
- Reset=0 at any rising edge, including mid-MEM with MemReq high:
  - State goes to IDLE; MulCnt, CycleCount and InstrCount go to 0.
  - All outputs are 0 on the following cycle.
  - Reset overrides Start and MemReady in the same cycle.

## Timing
- ALU or branch: 4 cycles (FETCH, DECODE, EXEC, WB).
- mul: 3+MulLatency cycles.
- lb: 5+W cycles; sb: 4+W cycles. W = number of MEM cycles with MemReady=0.
- halt: FETCH, DECODE, then HALT; Done goes high 2 cycles after FETCH is entered.
- Any asserted strobe (IRLoad, PCEn, RegWriteEn, MemWriteEn) is high for exactly one cycle per instruction.
- MemReq stays high continuously from MEM entry through the MemReady cycle inclusive.
- IDLE with Start=1 reaches FETCH on the next edge; there is no bubble.

## Test plan
- Reset=0 for 2 cycles, then Start=1 with an ALU instr (000_00_xxxx):
  - States go 0→1→2→3→5→1.
  - RegWriteEn and PCEn pulse once, in the WB cycle.
  - InstrCount=1 at the second FETCH.
- mul instr (111_10_xxxx), MulLatency=3: EXEC lasts 3 cycles, WB follows, and CycleCount=6 at the next FETCH.
- lb with MemReady low for 2 MEM cycles:
  - MemReq is high for 3 cycles and MemWriteEn stays 0.
  - RegWriteEn is high in WB; total 7 cycles.
- sb with MemReady=1 immediately:
  - MemWriteEn and PCEn are high together for 1 cycle and RegWriteEn is never 1.
  - Back in FETCH after 4 cycles.
- Branch with Cond=1, then with Cond=0: TakeBranch is 1 and then 0 in WB, with RegWriteEn=0 both times.
- Halt and reset cases:
  - Halt instr (111_11_xxxx) with Start held high: Done stays 1 and State stays 6 until Start=0, then State=0 next cycle.
  - Reset=0 asserted mid-MEM: every output and counter is 0 next cycle.
  - CycleCount preset near all-ones saturates at all-ones.
